// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES-128 round constants and round-function helpers
package aes_pkg;

  localparam int NR = 10;
  localparam logic [7:0] RCON [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = xtime(aa);
    end
    return acc;
  endfunction

  // Inverse as b^254 (b^2 * b^4 * ... * b^128), then the FIPS-197 affine map.
  function automatic logic [7:0] sbox_byte(input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] inv;
    p   = b;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_byte(w[31:24]), sbox_byte(w[23:16]), sbox_byte(w[15:8]), sbox_byte(w[7:0])};
  endfunction

  // Byte i sits at [127-8i -: 8]; row = i%4, column = i/4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES S-box (GF(2^8) inverse plus affine map)
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  assign out_byte = sbox_byte(in_byte);

endmodule

// File: rtl/aes_cipher.sv
// rtl/aes_cipher.sv - iterative free-running AES-128 encryption core, one round per clock
// Optional macro AES_CIPHER_ASSERT_EN compiles in simulation-only immediate assertions.
module aes_cipher
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] datain,
  input  logic [127:0] key,
  output logic [127:0] dataout,
  output logic         done
);

  logic [127:0] state_q, state_d;
  logic [127:0] rkey_q, rkey_d;
  logic [127:0] dataout_q, dataout_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         done_q, done_d;

  logic [127:0] sub_state, shifted, mixed, next_rkey;
  logic [31:0]  rot_w, sub_w, w0n, w1n, w2n, w3n;
  logic [7:0]   rcon;

  for (genvar i = 0; i < 16; i++) begin : g_sbox_state
    aes_sbox u_sbox (
      .in_byte  (state_q[127-8*i -: 8]),
      .out_byte (sub_state[127-8*i -: 8])
    );
  end

  for (genvar j = 0; j < 4; j++) begin : g_sbox_key
    aes_sbox u_sbox (
      .in_byte  (rot_w[31-8*j -: 8]),
      .out_byte (sub_w[31-8*j -: 8])
    );
  end

  assign rot_w = rot_word(rkey_q[31:0]);

  always_comb begin
    rcon = 8'h00;
    if (rnd_q != 4'd0 && rnd_q <= 4'(NR)) rcon = RCON[rnd_q];
    w0n       = rkey_q[127:96] ^ sub_w ^ {rcon, 24'h000000};
    w1n       = rkey_q[95:64] ^ w0n;
    w2n       = rkey_q[63:32] ^ w1n;
    w3n       = rkey_q[31:0] ^ w2n;
    next_rkey = {w0n, w1n, w2n, w3n};
    shifted   = shift_rows(sub_state);
    mixed     = mix_columns(shifted);
  end

  always_comb begin
    state_d   = state_q;
    rkey_d    = rkey_q;
    dataout_d = dataout_q;
    rnd_d     = rnd_q;
    done_d    = 1'b0;
    if (rnd_q == 4'd0) begin
      state_d = datain ^ key;
      rkey_d  = key;
      rnd_d   = 4'd1;
    end else begin
      rkey_d = next_rkey;
      if (rnd_q == 4'(NR)) begin
        dataout_d = shifted ^ next_rkey;
        done_d    = 1'b1;
        rnd_d     = 4'd0;
      end else begin
        state_d = mixed ^ next_rkey;
        rnd_d   = rnd_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= '0;
      rkey_q    <= '0;
      dataout_q <= '0;
      rnd_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rkey_q    <= rkey_d;
      dataout_q <= dataout_d;
      rnd_q     <= rnd_d;
      done_q    <= done_d;
    end
  end

  assign dataout = dataout_q;
  assign done    = done_q;

`ifdef AES_CIPHER_ASSERT_EN
  // Edges of the current block, counting the load edge as 1; done must land on edge 11.
  logic [3:0] blk_edges_q;
  logic       done_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_edges_q <= '0;
      done_prev_q <= 1'b0;
    end else begin
      done_prev_q <= done_q;
      if (rnd_q == 4'd0) blk_edges_q <= 4'd1;
      else if (blk_edges_q != 4'd0 && blk_edges_q != 4'd15) blk_edges_q <= blk_edges_q + 4'd1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      assert (rnd_q <= 4'(NR));
      assert (!(done_q && done_prev_q));
      assert (done_q == (blk_edges_q == 4'd11));
      if (done_q) assert (!$isunknown(dataout_q));
    end
  end
`endif

endmodule

// File: tb/tb_aes_cipher.sv
// tb/tb_aes_cipher.sv - self-checking bench for aes_cipher against a byte-array AES model
module tb_aes_cipher;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] datain = '0;
  logic [127:0] key = '0;
  logic [127:0] dataout;
  logic         done;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  logic [7:0] sbox_t [256];

  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_R1   = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  aes_cipher #(.NR(10)) dut (
    .clk     (clk),
    .rst     (rst),
    .datain  (datain),
    .key     (key),
    .dataout (dataout),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = (aa << 1) ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // Reference AES-128 over 16-entry byte arrays, index = 4*column + row.
  function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [127:0] k);
    logic [7:0] s [16];
    logic [7:0] w [16];
    logic [7:0] t [16];
    logic [7:0] tmp [4];
    logic [7:0] coef [4];
    logic [7:0] rc;
    logic [127:0] o;
    coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    for (int i = 0; i < 16; i++) begin
      w[i] = k[127-8*i -: 8];
      s[i] = pt[127-8*i -: 8] ^ w[i];
    end
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      tmp[0] = sbox_t[w[13]] ^ rc;
      tmp[1] = sbox_t[w[14]];
      tmp[2] = sbox_t[w[15]];
      tmp[3] = sbox_t[w[12]];
      for (int j = 0; j < 4; j++) w[j] = w[j] ^ tmp[j];
      for (int j = 4; j < 16; j++) w[j] = w[j] ^ w[j-4];
      rc = mul(rc, 8'h02);
      for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++)
          s[4*c+rr] = t[4*((c+rr)%4)+rr];
      if (r < 10) begin
        for (int i = 0; i < 16; i++) t[i] = s[i];
        for (int c = 0; c < 4; c++)
          for (int rr = 0; rr < 4; rr++) begin
            s[4*c+rr] = 8'h00;
            for (int j = 0; j < 4; j++)
              s[4*c+rr] = s[4*c+rr] ^ mul(coef[(j-rr+4)%4], t[4*c+j]);
          end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[i];
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // Entered at a negedge just before a load edge; leaves at the negedge after the done edge.
  task automatic run_block(input string tag, input logic [127:0] pt, input logic [127:0] k,
                           input logic [127:0] exp, input int chg_edge, input logic [127:0] chg_data,
                           input bit chk_r1, input logic [127:0] r1_exp);
    logic [127:0] prev;
    prev   = dataout;
    datain = pt;
    key    = k;
    for (int e = 1; e <= 11; e++) begin
      @(negedge clk);
      if (e == chg_edge) datain = chg_data;
      if (chk_r1 && e == 2) check({tag, " round1_state"}, dut.state_q, r1_exp);
      if (e < 11) begin
        check($sformatf("%s done_low_e%0d", tag, e), {127'd0, done}, 128'd0);
        if (e == 10) check({tag, " dataout_hold"}, dataout, prev);
      end else begin
        check({tag, " done_pulse"}, {127'd0, done}, 128'd1);
        check({tag, " dataout"}, dataout, exp);
      end
    end
  endtask

  initial begin
    logic [7:0] p, q;
    logic [127:0] pt, k;

    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ mul(p, 8'h02);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      sbox_t[p] = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;

    check("model_c1", ref_encrypt(C1_PT, C1_KEY), C1_CT);

    rst    = 1'b1;
    datain = C1_PT;
    key    = C1_KEY;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("reset_dataout_%0d", i), dataout, 128'd0);
      check($sformatf("reset_done_%0d", i), {127'd0, done}, 128'd0);
    end
    rst = 1'b0;

    run_block("fips_c1", C1_PT, C1_KEY, C1_CT, 0, '0, 1'b0, '0);
    run_block("fips_b", B_PT, B_KEY, B_CT, 0, '0, 1'b1, B_R1);
    run_block("zero", 128'd0, 128'd0, Z_CT, 0, '0, 1'b0, '0);
    run_block("midchange", C1_PT, C1_KEY, C1_CT, 5, 128'd0, 1'b0, '0);
    run_block("after_change", 128'd0, 128'd0, Z_CT, 0, '0, 1'b0, '0);

    datain = C1_PT;
    key    = C1_KEY;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midreset_dataout", dataout, 128'd0);
    check("midreset_done", {127'd0, done}, 128'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("midreset_hold_done_%0d", i), {127'd0, done}, 128'd0);
    end
    rst = 1'b0;
    run_block("post_reset", B_PT, B_KEY, B_CT, 0, '0, 1'b0, '0);

    for (int n = 0; n < 8; n++) begin
      pt = {$urandom, $urandom, $urandom, $urandom};
      k  = {$urandom, $urandom, $urandom, $urandom};
      run_block($sformatf("random_%0d", n), pt, k, ref_encrypt(pt, k), 0, '0, 1'b0, '0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
